// File: rtl/vai_pkg.sv
// vai_pkg: shared beat width, command codes and arbiter FSM states for vai_arbiter
package vai_pkg;
  localparam int BEAT_W = 8;
  localparam logic CMD_READ = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;
endpackage

// File: rtl/vai_rr_arbiter.sv
// vai_rr_arbiter: 2-way pick of one-hot winner from i_req; VAI_ARB_RR_EN adds last-grant pointer (i_update/i_grant) for round-robin, else requester 0 wins ties
module vai_rr_arbiter
  import vai_pkg::*;
(
  input  logic [1:0] i_req,
  output logic [1:0] o_pick
`ifdef VAI_ARB_RR_EN
  ,
  input  logic       Clk_i,
  input  logic       Reset_n_i,
  input  logic       i_update,
  input  logic [1:0] i_grant
`endif
);
`ifdef VAI_ARB_RR_EN
  logic r_last;
  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) r_last <= 1'b1;
    else if (i_update) r_last <= i_grant[1];
  end
  assign o_pick = &i_req ? (r_last ? 2'b01 : 2'b10) : i_req;
`else
  assign o_pick = i_req[0] ? 2'b01 : i_req;
`endif
endmodule

// File: rtl/vai_arbiter.sv
// vai_arbiter: 2-requester transaction arbiter (M0*/M1* request+response ports, S* shared slave ports, Grant_o one-hot owner); VAI_ARB_RR_EN selects round-robin over fixed priority
module vai_arbiter
  import vai_pkg::*;
(
  input  logic              Clk_i,
  input  logic              Reset_n_i,
  input  logic [BEAT_W-1:0] M0Din_i,
  input  logic              M0DinValid_i,
  input  logic              M0DinStart_i,
  input  logic              M0DinStop_i,
  output logic              M0DinAccept_o,
  output logic [BEAT_W-1:0] M0Dout_o,
  output logic              M0DoutValid_o,
  output logic              M0DoutStart_o,
  output logic              M0DoutStop_o,
  input  logic              M0DoutAccept_i,
  input  logic [BEAT_W-1:0] M1Din_i,
  input  logic              M1DinValid_i,
  input  logic              M1DinStart_i,
  input  logic              M1DinStop_i,
  output logic              M1DinAccept_o,
  output logic [BEAT_W-1:0] M1Dout_o,
  output logic              M1DoutValid_o,
  output logic              M1DoutStart_o,
  output logic              M1DoutStop_o,
  input  logic              M1DoutAccept_i,
  output logic [BEAT_W-1:0] SDin_o,
  output logic              SDinValid_o,
  output logic              SDinStart_o,
  output logic              SDinStop_o,
  input  logic              SDinAccept_i,
  input  logic [BEAT_W-1:0] SDout_i,
  input  logic              SDoutValid_i,
  input  logic              SDoutStart_i,
  input  logic              SDoutStop_i,
  output logic              SDoutAccept_o,
  output logic [1:0]        Grant_o
);
  state_t            r_state;
  logic [1:0]        r_grant;
  logic [BEAT_W-1:0] w_din [2];
  logic [1:0]        w_vld, w_start, w_stop, w_dacc, w_cand, w_pick;
  logic              w_sel, w_idle, w_req, w_rsp, w_done;
  assign w_din[0] = M0Din_i;
  assign w_din[1] = M1Din_i;
  assign w_vld    = {M1DinValid_i, M0DinValid_i};
  assign w_start  = {M1DinStart_i, M0DinStart_i};
  assign w_stop   = {M1DinStop_i, M0DinStop_i};
  assign w_dacc   = {M1DoutAccept_i, M0DoutAccept_i};
  assign w_cand   = w_vld & w_start;
  assign w_sel    = r_grant[1];
  // state qualifiers are gated by reset so every valid/accept drops while reset is held
  assign w_idle   = Reset_n_i && r_state == IDLE;
  assign w_req    = Reset_n_i && r_state == REQ;
  assign w_rsp    = Reset_n_i && r_state == RSP;
  assign SDin_o        = w_din[w_sel];
  assign SDinValid_o   = w_req && w_vld[w_sel];
  assign SDinStart_o   = w_start[w_sel];
  assign SDinStop_o    = w_stop[w_sel];
  // in IDLE a non-start beat is swallowed; start beats wait for the grant
  assign M0DinAccept_o = w_idle ? M0DinValid_i && !M0DinStart_i : w_req && r_grant[0] && SDinAccept_i;
  assign M1DinAccept_o = w_idle ? M1DinValid_i && !M1DinStart_i : w_req && r_grant[1] && SDinAccept_i;
  assign M0Dout_o      = SDout_i;
  assign M0DoutValid_o = w_rsp && r_grant[0] && SDoutValid_i;
  assign M0DoutStart_o = SDoutStart_i;
  assign M0DoutStop_o  = SDoutStop_i;
  assign M1Dout_o      = SDout_i;
  assign M1DoutValid_o = w_rsp && r_grant[1] && SDoutValid_i;
  assign M1DoutStart_o = SDoutStart_i;
  assign M1DoutStop_o  = SDoutStop_i;
  assign SDoutAccept_o = w_rsp && w_dacc[w_sel];
  assign w_done        = SDoutValid_i && SDoutAccept_o && SDoutStop_i;
  assign Grant_o       = r_grant;
  vai_rr_arbiter u_pick (
    .i_req     (w_cand),
    .o_pick    (w_pick)
`ifdef VAI_ARB_RR_EN
    ,
    .Clk_i     (Clk_i),
    .Reset_n_i (Reset_n_i),
    .i_update  (w_done),
    .i_grant   (r_grant)
`endif
  );
  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      r_state <= IDLE;
      r_grant <= '0;
    end else begin
      case (r_state)
        IDLE: if (|w_cand) begin
          r_state <= REQ;
          r_grant <= w_pick;
        end
        REQ: if (SDinValid_o && SDinAccept_i && SDinStop_o) r_state <= RSP;
        RSP: if (w_done) begin
          r_state <= IDLE;
          r_grant <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vai_arbiter.sv
// tb_vai_arbiter: directed and randomized checks of vai_arbiter against a transaction-level model
module tb_vai_arbiter;
  import vai_pkg::*;
  typedef struct packed {logic [7:0] d; logic s; logic p;} beat_t;
  logic       Clk_i = 1'b0, Reset_n_i = 1'b0;
  logic [7:0] M0Din_i, M1Din_i, SDin_o, SDout_i, M0Dout_o, M1Dout_o;
  logic       M0DinValid_i, M0DinStart_i, M0DinStop_i, M0DinAccept_o;
  logic       M0DoutValid_o, M0DoutStart_o, M0DoutStop_o, M0DoutAccept_i;
  logic       M1DinValid_i, M1DinStart_i, M1DinStop_i, M1DinAccept_o;
  logic       M1DoutValid_o, M1DoutStart_o, M1DoutStop_o, M1DoutAccept_i;
  logic       SDinValid_o, SDinStart_o, SDinStop_o, SDinAccept_i;
  logic       SDoutValid_i, SDoutStart_i, SDoutStop_i, SDoutAccept_o;
  logic [1:0] Grant_o;
  always #5 Clk_i = ~Clk_i;
  vai_arbiter dut (
    .Clk_i(Clk_i), .Reset_n_i(Reset_n_i),
    .M0Din_i(M0Din_i), .M0DinValid_i(M0DinValid_i), .M0DinStart_i(M0DinStart_i), .M0DinStop_i(M0DinStop_i),
    .M0DinAccept_o(M0DinAccept_o), .M0Dout_o(M0Dout_o), .M0DoutValid_o(M0DoutValid_o),
    .M0DoutStart_o(M0DoutStart_o), .M0DoutStop_o(M0DoutStop_o), .M0DoutAccept_i(M0DoutAccept_i),
    .M1Din_i(M1Din_i), .M1DinValid_i(M1DinValid_i), .M1DinStart_i(M1DinStart_i), .M1DinStop_i(M1DinStop_i),
    .M1DinAccept_o(M1DinAccept_o), .M1Dout_o(M1Dout_o), .M1DoutValid_o(M1DoutValid_o),
    .M1DoutStart_o(M1DoutStart_o), .M1DoutStop_o(M1DoutStop_o), .M1DoutAccept_i(M1DoutAccept_i),
    .SDin_o(SDin_o), .SDinValid_o(SDinValid_o), .SDinStart_o(SDinStart_o), .SDinStop_o(SDinStop_o),
    .SDinAccept_i(SDinAccept_i), .SDout_i(SDout_i), .SDoutValid_i(SDoutValid_i),
    .SDoutStart_i(SDoutStart_i), .SDoutStop_i(SDoutStop_i), .SDoutAccept_o(SDoutAccept_o),
    .Grant_o(Grant_o)
  );
  beat_t mq [2][$];
  beat_t sq[$];
  beat_t sreq[$];
  int owner = -1, phase = 0, last = 1, checks = 0, passes = 0;
  int p_sacc = 100, p_sval = 100, p_dacc = 100;
  function automatic beat_t mk(logic [7:0] d, logic s, logic p);
    return {d, s, p};
  endfunction
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask
  task automatic push_frame(int n, logic [7:0] hdr, int len);
    for (int i = 0; i < len; i++)
      mq[n].push_back(mk(i == 0 ? hdr : 8'($urandom), i == 0, i == len - 1));
  endtask
  // slave reply: header echo, a data beat for reads, then a 0x00 stop footer
  task automatic respond();
    logic [7:0] hdr;
    hdr = sreq[0].d;
    sq.push_back(mk(hdr, 1'b1, 1'b0));
    if (hdr[0] != CMD_WRITE) sq.push_back(mk(~hdr, 1'b0, 1'b0));
    sq.push_back(mk(8'h00, 1'b0, 1'b1));
    sreq.delete();
  endtask
  task automatic cycle();
    logic [1:0] v, dacc, xacc, xdval, cand, xg;
    logic       sacc, sval, xsval, xsacc;
    beat_t      h [2];
    beat_t      b;
    int         w, tie;
    for (int n = 0; n < 2; n++) begin
      v[n] = mq[n].size() > 0;
      h[n] = v[n] ? mq[n][0] : '0;
      dacc[n] = $urandom_range(99) < p_dacc;
    end
    sacc = $urandom_range(99) < p_sacc;
    sval = sq.size() > 0 && $urandom_range(99) < p_sval;
    {M0Din_i, M0DinStart_i, M0DinStop_i} = h[0];
    {M1Din_i, M1DinStart_i, M1DinStop_i} = h[1];
    M0DinValid_i = v[0];
    M1DinValid_i = v[1];
    M0DoutAccept_i = dacc[0];
    M1DoutAccept_i = dacc[1];
    SDinAccept_i = sacc;
    SDoutValid_i = sval;
    {SDout_i, SDoutStart_i, SDoutStop_i} = sval ? sq[0] : '0;
    #1;
    xg = owner < 0 ? 2'b00 : 2'(1 << owner);
    for (int n = 0; n < 2; n++) begin
      xacc[n] = Reset_n_i && (phase == 0 ? v[n] && !h[n].s : phase == 1 && owner == n && sacc);
      xdval[n] = Reset_n_i && phase == 2 && owner == n && sval;
    end
    xsval = Reset_n_i && (phase == 1 ? v[owner] : 1'b0);
    xsacc = Reset_n_i && (phase == 2 ? dacc[owner] : 1'b0);
    check("grant", Grant_o, xg);
    check("m0_din_accept", M0DinAccept_o, xacc[0]);
    check("m1_din_accept", M1DinAccept_o, xacc[1]);
    check("sdin_valid", SDinValid_o, xsval);
    check("m0_dout_valid", M0DoutValid_o, xdval[0]);
    check("m1_dout_valid", M1DoutValid_o, xdval[1]);
    check("sdout_accept", SDoutAccept_o, xsacc);
    if (xsval) check("sdin_beat", {SDin_o, SDinStart_o, SDinStop_o}, h[owner]);
    if (|xdval)
      check("dout_beat", owner == 0 ? {M0Dout_o, M0DoutStart_o, M0DoutStop_o}
                                    : {M1Dout_o, M1DoutStart_o, M1DoutStop_o}, sq[0]);
    if (!Reset_n_i) begin
      owner = -1; phase = 0; last = 1;
      sq.delete(); sreq.delete();
    end else if (phase == 0) begin
      for (int n = 0; n < 2; n++) if (v[n] && !h[n].s) void'(mq[n].pop_front());
      cand = v & {h[1].s, h[0].s};
`ifdef VAI_ARB_RR_EN
      tie = 1 - last;
`else
      tie = 0;
`endif
      if (|cand) begin
        w = &cand ? tie : (cand[0] ? 0 : 1);
        owner = w; phase = 1;
      end
    end else if (phase == 1) begin
      if (v[owner] && sacc) begin
        b = mq[owner].pop_front();
        sreq.push_back(b);
        if (b.p) begin respond(); phase = 2; end
      end
    end else if (sval && dacc[owner]) begin
      b = sq.pop_front();
      if (b.p) begin last = owner; owner = -1; phase = 0; end
    end
    @(posedge Clk_i); #1;
  endtask
  task automatic run_idle(int budget);
    int k;
    k = 0;
    do begin cycle(); k++; end
    while (!(phase == 0 && mq[0].size() == 0 && mq[1].size() == 0) && k < budget);
  endtask
  task automatic run_until_phase(int ph, int budget);
    int k;
    k = 0;
    while (phase != ph && k < budget) begin cycle(); k++; end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    {M0Din_i, M0DinValid_i, M0DinStart_i, M0DinStop_i, M0DoutAccept_i} = '0;
    {M1Din_i, M1DinValid_i, M1DinStart_i, M1DinStop_i, M1DoutAccept_i} = '0;
    {SDinAccept_i, SDout_i, SDoutValid_i, SDoutStart_i, SDoutStop_i} = '0;
    @(posedge Clk_i); #1;
    cycle(); cycle();
    Reset_n_i = 1'b1;
    cycle();
    check("reset_grant", Grant_o, 2'b00);
    mq[0].push_back(mk({7'h18, CMD_WRITE}, 1'b1, 1'b0));
    mq[0].push_back(mk(8'hA5, 1'b0, 1'b1));
    cycle();
    check("wr_grant", Grant_o, 2'b01);
    run_idle(50);
    mq[0].push_back(mk(8'h55, 1'b0, 1'b0));
    cycle();
    check("stray_empty", 32'(mq[0].size()), 0);
    check("stray_grant", Grant_o, 2'b00);
    p_sacc = 30; p_dacc = 30;
    mq[1].push_back(mk({7'h10, CMD_READ}, 1'b1, 1'b1));
    cycle();
    check("rd_grant", Grant_o, 2'b10);
    run_idle(200);
    p_sacc = 100; p_dacc = 100;
    push_frame(0, 8'h40, 2); push_frame(0, 8'h41, 2); push_frame(1, 8'h42, 2);
    cycle();
    check("tie_first", Grant_o, 2'b01);
    run_until_phase(0, 50);
    cycle();
`ifdef VAI_ARB_RR_EN
    check("tie_second", Grant_o, 2'b10);
`else
    check("tie_second", Grant_o, 2'b01);
`endif
    run_idle(100);
    p_dacc = 0;
    push_frame(0, {7'h18, CMD_WRITE}, 2);
    run_until_phase(2, 30);
    cycle(); cycle();
    Reset_n_i = 1'b0;
    cycle();
    Reset_n_i = 1'b1;
    check("rst_grant", Grant_o, 2'b00);
    check("rst_m0_dout_valid", M0DoutValid_o, 1'b0);
    p_dacc = 100;
    mq[1].push_back(mk({7'h10, CMD_READ}, 1'b1, 1'b1));
    cycle();
    check("post_rst_grant", Grant_o, 2'b10);
    run_idle(50);
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        p_sacc = $urandom_range(100, 20);
        p_sval = $urandom_range(100, 20);
        p_dacc = $urandom_range(100, 20);
      end
      for (int n = 0; n < 2; n++)
        if (mq[n].size() == 0 && $urandom_range(7) == 0) begin
          if ($urandom_range(3) == 0) mq[n].push_back(mk(8'($urandom), 1'b0, 1'($urandom)));
          push_frame(n, 8'($urandom), $urandom_range(4, 1));
        end
      cycle();
    end
    p_sacc = 100; p_sval = 100; p_dacc = 100;
    run_idle(300);
    check("final_grant", Grant_o, 2'b00);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
